// File: rtl/imem_prog_if.sv
// Fetch/load bus of the loadable instruction memory. The CPU/loader side uses
// the master modport, the memory uses the slave modport.
interface imem_prog_if #(
   parameter int PC_W   = 16,
   parameter int DATA_W = 32
);
   logic              load_en;
   logic [PC_W-1:0]   load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_done;
   logic              fetch_req;
   logic [PC_W-1:0]   fetch_pc;
   logic              stall;
   logic              flush;
   logic              fetch_ready;
   logic [DATA_W-1:0] instr;
   logic [PC_W-1:0]   instr_pc;
   logic              instr_valid;
   logic              oob;
   logic [PC_W-1:0]   prog_len;
   logic              load_err;
   logic [1:0]        dbg_state;

   // Handshake: a fetch is taken on a rising edge where fetch_req and
   // fetch_ready are both high; instr/instr_pc/oob are valid one cycle later
   // while instr_valid is high. Loads have no handshake and are taken every
   // cycle load_en is high.
   modport master (
      output load_en, load_addr, load_data, load_done,
      output fetch_req, fetch_pc, stall, flush,
      input  fetch_ready, instr, instr_pc, instr_valid, oob,
      input  prog_len, load_err, dbg_state
   );

   modport slave (
      input  load_en, load_addr, load_data, load_done,
      input  fetch_req, fetch_pc, stall, flush,
      output fetch_ready, instr, instr_pc, instr_valid, oob,
      output prog_len, load_err, dbg_state
   );
endinterface

// File: rtl/imem_prog.sv
// Loadable instruction memory: program written through the load port, then
// served as word-indexed fetches with a registered one-cycle read.
module imem_prog #(
   parameter int                PC_W     = 16,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 64,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic       clk,
   input  logic       rst,
   imem_prog_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PC_W:0] DEPTH_X = DEPTH[PC_W:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  written_q;

   logic [DATA_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
   logic              valid_q, valid_d;
   logic              oob_q, oob_d;
   logic [PC_W-1:0]   prog_len_q, prog_len_d;
   logic              load_err_q, load_err_d;

   logic              load_in_range, load_ok, fetch_in_range, accept, ready;
   logic [AW-1:0]     load_idx, fetch_idx;
   logic [DATA_W-1:0] read_word;

   // Range checks use the full PC width: there is no address wrap.
   assign load_in_range  = ({1'b0, bus.load_addr} < DEPTH_X);
   assign fetch_in_range = ({1'b0, bus.fetch_pc} < DEPTH_X);
   assign load_idx       = bus.load_addr[AW-1:0];
   assign fetch_idx      = bus.fetch_pc[AW-1:0];
   assign load_ok        = bus.load_en & load_in_range;
   assign accept         = bus.fetch_req & ready;
   assign read_word      = (fetch_in_range && written_q[fetch_idx]) ? mem_q[fetch_idx] : NOP_WORD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.load_done)    state_d = RUN;
            else if (bus.load_en) state_d = LOAD;
         end
         LOAD:    if (bus.load_done) state_d = RUN;
         RUN:     if (bus.load_en)   state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready         = (state_q == RUN) & ~bus.stall & ~bus.load_en;
      bus.dbg_state = state_q;
   end

   // Array contents are not reset; the written bitmap masks stale words.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         mem_q[load_idx] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         written_q <= '0;
      end else if (load_ok) begin
         written_q[load_idx] <= 1'b1;
      end
   end

   always_comb begin
      prog_len_d = prog_len_q;
      load_err_d = load_err_q;
      if (load_ok && (bus.load_addr >= prog_len_q)) begin
         prog_len_d = bus.load_addr + 1'b1;
      end
      if (bus.load_en && !load_in_range) begin
         load_err_d = 1'b1;
      end
   end

   // A new fetch beats flush; flush beats stall for instr_valid only.
   always_comb begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      oob_d      = oob_q;
      valid_d    = valid_q;
      if (accept) begin
         instr_d    = read_word;
         instr_pc_d = bus.fetch_pc;
         oob_d      = ~fetch_in_range;
         valid_d    = 1'b1;
      end else if (bus.flush || !bus.stall) begin
         valid_d = 1'b0;
      end
      if (bus.load_en && state_q == RUN) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= NOP_WORD;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         oob_q      <= 1'b0;
         prog_len_q <= '0;
         load_err_q <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         oob_q      <= oob_d;
         prog_len_q <= prog_len_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.fetch_ready = ready;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.oob         = oob_q;
   assign bus.prog_len    = prog_len_q;
   assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: directed program/fetch scenarios plus random traffic,
// checked against a word-array reference model and a fetch scoreboard.
module tb_imem_prog;

   localparam int PC_W   = 16;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int EW     = DATA_W + PC_W + 1;
   localparam int S_IDLE = 0;
   localparam int S_LOAD = 1;
   localparam int S_RUN  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_prog_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

   imem_prog #(
      .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD('0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected fetch responses packed as {oob, pc, instr}.
   logic [EW-1:0] exp_q [$];

   // Reference model state.
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_wr  [DEPTH];
   int                m_state;
   int                m_len;
   bit                m_err;
   bit                m_valid;
   logic [DATA_W-1:0] m_instr;
   int                m_pc;
   bit                m_oob;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_read(input int pc);
      if (pc < DEPTH && m_wr[pc]) return m_mem[pc];
      return '0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
      m_state = S_IDLE;
      m_len   = 0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_instr = '0;
      m_pc    = 0;
      m_oob   = 1'b0;
      exp_q.delete();
   endtask

   // One clock of stimulus, called at a falling edge; returns at the next one.
   task automatic cyc(input bit req, input int pc, input bit st, input bit fl,
                      input bit le, input int la, input logic [DATA_W-1:0] ld, input bit dn);
      bit exp_ready;
      bit acc;
      logic [PC_W-1:0] pcv;
      pcv = pc[PC_W-1:0];
      bus.fetch_req = req;
      bus.fetch_pc  = pcv;
      bus.stall     = st;
      bus.flush     = fl;
      bus.load_en   = le;
      bus.load_addr = la[PC_W-1:0];
      bus.load_data = ld;
      bus.load_done = dn;
      #1;
      exp_ready = (m_state == S_RUN) && !st && !le;
      chk("fetch_ready", 64'(bus.fetch_ready), 64'(exp_ready));
      acc = req && exp_ready;
      if (acc) begin
         exp_q.push_back({pc >= DEPTH, pcv, model_read(pc)});
         m_valid = 1'b1;
         m_instr = model_read(pc);
         m_pc    = pc;
         m_oob   = (pc >= DEPTH);
      end else if (fl || !st) begin
         m_valid = 1'b0;
      end
      if (le && m_state == S_RUN) m_valid = 1'b0;
      if (le) begin
         if (la < DEPTH) begin
            m_mem[la] = ld;
            m_wr[la]  = 1'b1;
            if (la + 1 > m_len) m_len = la + 1;
         end else begin
            m_err = 1'b1;
         end
      end
      if (m_state == S_RUN) begin
         if (le) m_state = S_LOAD;
      end else if (dn) begin
         m_state = S_RUN;
      end else if (le) begin
         m_state = S_LOAD;
      end
      @(negedge clk);
      chk("instr_valid", 64'(bus.instr_valid), 64'(m_valid));
      chk("instr", 64'(bus.instr), 64'(m_instr));
      chk("instr_pc", 64'(bus.instr_pc), 64'(m_pc));
      chk("oob", 64'(bus.oob), 64'(m_oob));
      chk("prog_len", 64'(bus.prog_len), 64'(m_len));
      chk("load_err", 64'(bus.load_err), 64'(m_err));
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 0, 0, '0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
      chk({tag, "_instr"}, 64'(bus.instr), 64'd0);
      chk({tag, "_pc"}, 64'(bus.instr_pc), 64'd0);
      chk({tag, "_oob"}, 64'(bus.oob), 64'd0);
      chk({tag, "_prog_len"}, 64'(bus.prog_len), 64'd0);
      chk({tag, "_load_err"}, 64'(bus.load_err), 64'd0);
   endtask

   // Monitor: every DUT-side fetch handshake must match a queued expectation.
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         if (!rst && bus.fetch_req && bus.fetch_ready) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               chk("unexpected_fetch", 64'(bus.instr_pc), 64'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("sb_instr", 64'(bus.instr), 64'(e[DATA_W-1:0]));
               chk("sb_pc", 64'(bus.instr_pc), 64'(e[DATA_W +: PC_W]));
               chk("sb_oob", 64'(bus.oob), 64'(e[EW-1]));
               chk("sb_valid", 64'(bus.instr_valid), 64'd1);
            end
         end
      end
   end

   initial begin
      bus.fetch_req = 1'b0;
      bus.fetch_pc  = '0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.load_done = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_ready", 64'(bus.fetch_ready), 64'd0);
      rst = 1'b0;

      // Directed program and fetches.
      cyc(0, 0, 0, 0, 1, 0, 32'h0000_0000, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'hC821_0005, 0);
      cyc(0, 0, 0, 0, 0, 0, '0, 1);
      cyc(1, 1, 0, 0, 0, 0, '0, 0);
      cyc(1, 5, 0, 0, 0, 0, '0, 0);
      cyc(1, 70, 0, 0, 0, 0, '0, 0);
      cyc(1, 1, 0, 0, 0, 0, '0, 0);
      repeat (3) cyc(1, 2, 1, 0, 0, 0, '0, 0);
      cyc(1, 2, 1, 1, 0, 0, '0, 0);
      cyc(1, 1, 0, 0, 0, 0, '0, 0);
      cyc(1, 0, 0, 1, 0, 0, '0, 0);
      idle_cyc();
      cyc(1, 1, 0, 0, 0, 0, '0, 0);
      cyc(1, 3, 0, 0, 1, 100, 32'hDEAD_BEEF, 0);
      cyc(1, 3, 0, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, 1, 63, 32'h1234_5678, 1);
      cyc(1, 63, 0, 0, 0, 0, '0, 0);
      cyc(1, 64, 0, 0, 0, 0, '0, 0);
      idle_cyc();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 80),
             $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
             $urandom_range(0, 19) < 2, $urandom_range(0, 70),
             $urandom(), $urandom_range(0, 19) < 2);
      end
      cyc(0, 0, 0, 0, 0, 0, '0, 1);
      cyc(1, 1, 0, 0, 0, 0, '0, 0);

      // Asynchronous reset in the middle of a fetch with valid output.
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = 16'd2;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, '0, 1);
      cyc(1, 1, 0, 0, 0, 0, '0, 0);
      idle_cyc();

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_prog.md
Name: imem_prog

Overview:
- Parametrised, loadable successor to the hardcoded instruction ROM.
- Holds a program in a DEPTH-word array that is written through a load port, then serves word-indexed fetches (PC increments by 1 per instruction) with a registered 1-cycle read, stall, flush and out-of-range detection.
- Sits between the PC/fetch stage and the decode stage of the project CPU, so test programs can be swapped at simulation time without editing RTL.

Parameters:
- PC_W, 16, width of fetch_pc, load_addr and instr_pc.
- DATA_W, 32, instruction width.
- DEPTH, 64, number of instruction words (1..2^PC_W).
- NOP_WORD, 0, word returned for unwritten or out-of-range addresses.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  write load_data to load_addr this cycle
- load_addr  in  PC_W  word address of the load
- load_data  in  DATA_W  instruction word to store
- load_done  in  1  one-cycle pulse: program complete, enter RUN
- fetch_req  in  1  request the instruction at fetch_pc
- fetch_pc  in  PC_W  word address to fetch
- stall  in  1  hold outputs; no fetch is accepted
- flush  in  1  discard the registered instruction
- fetch_ready  out  1  = (state==RUN) & ~stall & ~load_en; combinational
- instr  out  DATA_W  fetched instruction (registered)
- instr_pc  out  PC_W  address of instr (registered)
- instr_valid  out  1  instr/instr_pc are meaningful
- oob  out  1  instr came from an address >= DEPTH
- prog_len  out  PC_W  highest in-range loaded address + 1
- load_err  out  1  sticky: a load with load_addr >= DEPTH occurred

Behaviour:
- Reset (async, any state, including mid-load or mid-fetch):
  - state=IDLE; instr=NOP_WORD; instr_pc=0; instr_valid=0; oob=0; prog_len=0; load_err=0.
  - A per-word written bitmap is cleared. Array contents need not be reset, because unwritten words always read as NOP_WORD.
- FSM states and transitions:
  - IDLE -> LOAD on load_en.
  - LOAD -> RUN on load_done. load_done in IDLE goes straight to RUN with an empty program (all fetches return NOP_WORD).
  - RUN -> LOAD on load_en. instr_valid clears at the same edge.
  - load_done outside LOAD/IDLE is ignored.
- Load (any state, load_en=1):
  - If load_addr < DEPTH: mem[load_addr]<=load_data; set written bit; prog_len<=max(prog_len, load_addr+1).
  - Otherwise: no write, load_err<=1.
  - load_en and load_done in the same cycle: the write happens and the state goes to RUN.
  - Rewriting an address overwrites the word.
- Fetch acceptance: a fetch is accepted when fetch_req & fetch_ready. Latency is 1 cycle. At that edge:
  - instr<=(fetch_pc<DEPTH & written[fetch_pc]) ? mem[fetch_pc] : NOP_WORD
  - instr_pc<=fetch_pc; oob<=(fetch_pc>=DEPTH); instr_valid<=1.
- No accepted fetch and no flush: if stall=1, all outputs hold. Otherwise instr_valid<=0, and instr/instr_pc/oob hold their last values.
- Flush:
  - Alone: instr_valid<=0.
  - flush together with an accepted fetch (branch redirect): the new fetch wins and instr_valid<=1 with the new word.
  - flush overrides stall for instr_valid only; instr/instr_pc hold.
- Load priority: load_en blocks fetch acceptance in the same cycle (fetch_ready=0); the fetch port is only serviced when no load is in progress that cycle.
- Address wrap: there is none. fetch_pc is never truncated modulo DEPTH, so the out-of-range check uses the full PC_W.

Test Plan:
- Reset, load addr0=0x00000000 and addr1=0xC8210005, pulse load_done, fetch pc=1 -> next cycle instr=0xC8210005, instr_pc=1, instr_valid=1, prog_len=2, oob=0.
- In RUN, fetch pc=5 (never written) -> instr=0x00000000, valid=1, oob=0; fetch pc=70 (DEPTH=64) -> instr=0, oob=1.
- Fetch pc=1, then stall=1 for 3 cycles with fetch_req=1 -> fetch_ready=0, instr stays 0xC8210005 and valid stays 1 for all 3 cycles; flush during the stall -> valid=0 next cycle.
- flush with fetch_req pc=0 in the same cycle -> next cycle valid=1, instr_pc=0.
- load_addr=100 with DEPTH=64 -> load_err=1, prog_len unchanged; load_en in RUN -> state LOAD, fetch_ready=0, instr_valid=0 next cycle.
- Assert rst asynchronously mid-fetch with valid=1 -> instr_valid=0 and prog_len=0 immediately; after load_done with no loads, fetch pc=1 -> NOP_WORD.
